// File: rtl/udma_sdio_pkg.sv
// Shared definitions for the uDMA SDIO register file: word addresses, STATUS bits,
// DATA_SETUP field layout and the command-sequencer state encoding.
package udma_sdio_pkg;

    localparam logic [4:0] REG_CMD_OP     = 5'h08;
    localparam logic [4:0] REG_CMD_ARG    = 5'h09;
    localparam logic [4:0] REG_DATA_SETUP = 5'h0A;
    localparam logic [4:0] REG_START      = 5'h0B;
    localparam logic [4:0] REG_RSP0       = 5'h0C;
    localparam logic [4:0] REG_RSP1       = 5'h0D;
    localparam logic [4:0] REG_RSP2       = 5'h0E;
    localparam logic [4:0] REG_RSP3       = 5'h0F;
    localparam logic [4:0] REG_STATUS     = 5'h11;

    localparam int STATUS_EOT_BIT  = 0;
    localparam int STATUS_ERR_BIT  = 1;
    localparam int STATUS_INFO_LSB = 16;

    // Writing ones to eot/err in STATUS clears them
    localparam logic [31:0] STATUS_CLR_MASK = 32'h0000_0003;
    localparam logic [31:0] START_CMD       = 32'h0000_0001;

    localparam int SETUP_EN_BIT      = 0;
    localparam int SETUP_RWN_BIT     = 1;
    localparam int SETUP_QUAD_BIT    = 2;
    localparam int SETUP_BLKNUM_LSB  = 8;
    localparam int SETUP_BLKSIZE_LSB = 16;

    typedef enum logic [3:0] {
        SEQ_IDLE,
        SEQ_WR_OP,
        SEQ_WR_ARG,
        SEQ_WR_SETUP,
        SEQ_WR_START,
        SEQ_POLL,
        SEQ_GAP,
        SEQ_RD_RSP,
        SEQ_CLR,
        SEQ_DONE
    } seq_state_e;

    function automatic logic [25:0] setup_image(
        input logic       en,
        input logic       rwn,
        input logic       quad,
        input logic [7:0] blk_num,
        input logic [9:0] blk_size
    );
        logic [25:0] img;
        img                              = '0;
        img[SETUP_EN_BIT]                = en;
        img[SETUP_RWN_BIT]               = rwn;
        img[SETUP_QUAD_BIT]              = quad;
        img[SETUP_BLKNUM_LSB +: 8]       = blk_num;
        img[SETUP_BLKSIZE_LSB +: 10]     = blk_size;
        return img;
    endfunction

endpackage

// File: rtl/udma_sdio_cmd_seq.sv
// Cfg-bus initiator that runs one SD command through the uDMA SDIO register file.
// UDMA_SDIO_SEQ_RSP_READ_EN: when defined, RSP0..RSP3 are read back after completion.
module udma_sdio_cmd_seq
    import udma_sdio_pkg::*;
#(
    parameter int POLL_GAP  = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [5:0]   req_op_i,
    input  logic [31:0]  req_arg_i,
    input  logic [2:0]   req_rsp_type_i,
    input  logic [25:0]  req_data_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [127:0] rsp_data_o,
    output logic [15:0]  rsp_status_o,
    output logic         rsp_err_o,
    output logic         rsp_timeout_o,
    output logic [4:0]   cfg_addr_o,
    output logic [31:0]  cfg_data_o,
    output logic         cfg_valid_o,
    output logic         cfg_rwn_o,
    input  logic [31:0]  cfg_data_i,
    input  logic         cfg_ready_i
);

    localparam int GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
    localparam logic [TIMEOUT_W-1:0] POLL_MAX = {TIMEOUT_W{1'b1}};

    seq_state_e           state_reg, state_next;
    logic [5:0]           op_reg, op_next;
    logic [31:0]          arg_reg, arg_next;
    logic [2:0]           rsp_type_reg, rsp_type_next;
    logic [25:0]          setup_reg, setup_next;
    logic [TIMEOUT_W-1:0] poll_cnt_reg, poll_cnt_next;
    logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;
    logic [15:0]          status_reg, status_next;
    logic                 err_reg, err_next;
    logic                 timeout_reg, timeout_next;
    logic                 cfg_valid_reg, cfg_valid_next;
    logic [4:0]           cfg_addr_reg, cfg_addr_next;
    logic [31:0]          cfg_data_reg, cfg_data_next;
    logic                 cfg_rwn_reg, cfg_rwn_next;
    logic                 beat_done;
    logic                 poll_hit;
    logic                 unused_status_bits;
`ifdef UDMA_SDIO_SEQ_RSP_READ_EN
    logic [1:0]           rsp_idx_reg, rsp_idx_next;
    logic [127:0]         rsp_data_reg, rsp_data_next;
`endif

    assign beat_done          = cfg_valid_reg & cfg_ready_i;
    assign poll_hit           = cfg_data_i[STATUS_EOT_BIT] | cfg_data_i[STATUS_ERR_BIT];
    assign unused_status_bits = ^cfg_data_i[15:2];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg     <= SEQ_IDLE;
            op_reg        <= '0;
            arg_reg       <= '0;
            rsp_type_reg  <= '0;
            setup_reg     <= '0;
            poll_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
            status_reg    <= '0;
            err_reg       <= 1'b0;
            timeout_reg   <= 1'b0;
            cfg_valid_reg <= 1'b0;
            cfg_addr_reg  <= '0;
            cfg_data_reg  <= '0;
            cfg_rwn_reg   <= 1'b0;
`ifdef UDMA_SDIO_SEQ_RSP_READ_EN
            rsp_idx_reg   <= '0;
            rsp_data_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            arg_reg       <= arg_next;
            rsp_type_reg  <= rsp_type_next;
            setup_reg     <= setup_next;
            poll_cnt_reg  <= poll_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            status_reg    <= status_next;
            err_reg       <= err_next;
            timeout_reg   <= timeout_next;
            cfg_valid_reg <= cfg_valid_next;
            cfg_addr_reg  <= cfg_addr_next;
            cfg_data_reg  <= cfg_data_next;
            cfg_rwn_reg   <= cfg_rwn_next;
`ifdef UDMA_SDIO_SEQ_RSP_READ_EN
            rsp_idx_reg   <= rsp_idx_next;
            rsp_data_reg  <= rsp_data_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        arg_next      = arg_reg;
        rsp_type_next = rsp_type_reg;
        setup_next    = setup_reg;
        poll_cnt_next = poll_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        status_next   = status_reg;
        err_next      = err_reg;
        timeout_next  = timeout_reg;
`ifdef UDMA_SDIO_SEQ_RSP_READ_EN
        rsp_idx_next  = rsp_idx_reg;
        rsp_data_next = rsp_data_reg;
`endif
        case (state_reg)
            SEQ_IDLE: begin
                if (req_valid_i) begin
                    op_next       = req_op_i;
                    arg_next      = req_arg_i;
                    rsp_type_next = req_rsp_type_i;
                    setup_next    = req_data_i;
                    poll_cnt_next = '0;
                    gap_cnt_next  = '0;
                    status_next   = '0;
                    err_next      = 1'b0;
                    timeout_next  = 1'b0;
`ifdef UDMA_SDIO_SEQ_RSP_READ_EN
                    rsp_idx_next  = '0;
                    rsp_data_next = '0;
`endif
                    state_next    = SEQ_WR_OP;
                end
            end
            SEQ_WR_OP:    if (beat_done) state_next = SEQ_WR_ARG;
            SEQ_WR_ARG:   if (beat_done) state_next = SEQ_WR_SETUP;
            SEQ_WR_SETUP: if (beat_done) state_next = SEQ_WR_START;
            SEQ_WR_START: if (beat_done) state_next = SEQ_POLL;
            SEQ_POLL: begin
                if (beat_done) begin
                    if (poll_hit) begin
                        status_next = cfg_data_i[STATUS_INFO_LSB +: 16];
                        err_next    = cfg_data_i[STATUS_ERR_BIT];
`ifdef UDMA_SDIO_SEQ_RSP_READ_EN
                        rsp_idx_next = '0;
                        state_next   = SEQ_RD_RSP;
`else
                        state_next   = SEQ_CLR;
`endif
                    end else if (poll_cnt_reg == POLL_MAX - 1'b1) begin
                        // This miss exhausts the poll budget
                        poll_cnt_next = POLL_MAX;
                        timeout_next  = 1'b1;
                        state_next    = SEQ_CLR;
                    end else begin
                        poll_cnt_next = poll_cnt_reg + 1'b1;
                        gap_cnt_next  = '0;
                        state_next    = (POLL_GAP == 0) ? SEQ_POLL : SEQ_GAP;
                    end
                end
            end
            SEQ_GAP: begin
                if (gap_cnt_reg == GAP_W'(GAP_LAST)) begin
                    state_next = SEQ_POLL;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
`ifdef UDMA_SDIO_SEQ_RSP_READ_EN
            SEQ_RD_RSP: begin
                if (beat_done) begin
                    rsp_data_next[32*rsp_idx_reg +: 32] = cfg_data_i;
                    if (rsp_idx_reg == 2'd3) begin
                        state_next = SEQ_CLR;
                    end else begin
                        rsp_idx_next = rsp_idx_reg + 2'd1;
                    end
                end
            end
`endif
            SEQ_CLR:  if (beat_done) state_next = SEQ_DONE;
            SEQ_DONE: if (rsp_ready_i) state_next = SEQ_IDLE;
            default:  state_next = SEQ_IDLE;
        endcase
    end

    // The beat for the state being entered is registered now, so the bus never
    // idles between beats and holds steady while the state waits for ready.
    always_comb begin
        cfg_valid_next = 1'b0;
        cfg_addr_next  = '0;
        cfg_data_next  = '0;
        cfg_rwn_next   = 1'b0;
        case (state_next)
            SEQ_WR_OP: begin
                cfg_valid_next = 1'b1;
                cfg_addr_next  = REG_CMD_OP;
                cfg_data_next  = {18'h0, op_next, 5'h0, rsp_type_next};
            end
            SEQ_WR_ARG: begin
                cfg_valid_next = 1'b1;
                cfg_addr_next  = REG_CMD_ARG;
                cfg_data_next  = arg_next;
            end
            SEQ_WR_SETUP: begin
                cfg_valid_next = 1'b1;
                cfg_addr_next  = REG_DATA_SETUP;
                cfg_data_next  = {6'h0, setup_next};
            end
            SEQ_WR_START: begin
                cfg_valid_next = 1'b1;
                cfg_addr_next  = REG_START;
                cfg_data_next  = START_CMD;
            end
            SEQ_POLL: begin
                cfg_valid_next = 1'b1;
                cfg_addr_next  = REG_STATUS;
                cfg_rwn_next   = 1'b1;
            end
`ifdef UDMA_SDIO_SEQ_RSP_READ_EN
            SEQ_RD_RSP: begin
                cfg_valid_next = 1'b1;
                cfg_rwn_next   = 1'b1;
                case (rsp_idx_next)
                    2'd0:    cfg_addr_next = REG_RSP0;
                    2'd1:    cfg_addr_next = REG_RSP1;
                    2'd2:    cfg_addr_next = REG_RSP2;
                    default: cfg_addr_next = REG_RSP3;
                endcase
            end
`endif
            SEQ_CLR: begin
                cfg_valid_next = 1'b1;
                cfg_addr_next  = REG_STATUS;
                cfg_data_next  = STATUS_CLR_MASK;
            end
            default: ;
        endcase
    end

    assign req_ready_o   = (state_reg == SEQ_IDLE);
    assign rsp_valid_o   = (state_reg == SEQ_DONE);
    assign rsp_status_o  = status_reg;
    assign rsp_err_o     = err_reg;
    assign rsp_timeout_o = timeout_reg;
    assign cfg_valid_o   = cfg_valid_reg;
    assign cfg_addr_o    = cfg_addr_reg;
    assign cfg_data_o    = cfg_data_reg;
    assign cfg_rwn_o     = cfg_rwn_reg;
`ifdef UDMA_SDIO_SEQ_RSP_READ_EN
    assign rsp_data_o    = rsp_data_reg;
`else
    assign rsp_data_o    = '0;
`endif

endmodule

// File: tb/tb_udma_sdio_cmd_seq.sv
// Directed bench for udma_sdio_cmd_seq against a small SDIO register-file responder.
module tb_udma_sdio_cmd_seq;
    import udma_sdio_pkg::*;

    logic         clk;
    logic         rstn;
    logic         req_valid;
    logic         req_ready_o;
    logic [5:0]   req_op;
    logic [31:0]  req_arg;
    logic [2:0]   req_rsp_type;
    logic [25:0]  req_data;
    logic         rsp_valid_o;
    logic         rsp_ready;
    logic [127:0] rsp_data_o;
    logic [15:0]  rsp_status_o;
    logic         rsp_err_o;
    logic         rsp_timeout_o;
    logic [4:0]   cfg_addr_o;
    logic [31:0]  cfg_data_o;
    logic         cfg_valid_o;
    logic         cfg_rwn_o;
    logic [31:0]  cfg_rdata;
    logic         cfg_ready;

    int tests_run = 0;
    int tests_failed = 0;

    // responder / monitor state
    int           cyc = 0;
    bit           stall_mode = 0;
    int           eot_poll = 0;
    logic [31:0]  status_done = 32'h0;
    logic [31:0]  rsp_mem [4];
    logic [37:0]  log_beat [64];
    int           log_n = 0;
    int           log_polls = 0;
    int           poll_cyc [16];
    bit           stall_pend = 0;
    logic [38:0]  stall_snap = '0;
    int           stall_err = 0;
    logic [37:0]  exp_beat [64];
    int           exp_n = 0;

    udma_sdio_cmd_seq #(
        .POLL_GAP (8),
        .TIMEOUT_W(3)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op),
        .req_arg_i     (req_arg),
        .req_rsp_type_i(req_rsp_type),
        .req_data_i    (req_data),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data_o),
        .rsp_status_o  (rsp_status_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .cfg_addr_o    (cfg_addr_o),
        .cfg_data_o    (cfg_data_o),
        .cfg_valid_o   (cfg_valid_o),
        .cfg_rwn_o     (cfg_rwn_o),
        .cfg_data_i    (cfg_rdata),
        .cfg_ready_i   (cfg_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // STATUS reports eot/err once the eot_poll-th read is pending (log_polls counts it)
    always_comb begin
        cfg_rdata = 32'h0;
        if (cfg_addr_o == REG_STATUS) begin
            if (eot_poll != 0 && log_polls >= eot_poll) cfg_rdata = status_done;
        end else if (cfg_addr_o >= REG_RSP0 && cfg_addr_o <= REG_RSP3) begin
            cfg_rdata = rsp_mem[cfg_addr_o[1:0]];
        end
    end

    always @(negedge clk) begin
        cyc++;
        cfg_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (stall_pend && ({cfg_valid_o, cfg_addr_o, cfg_data_o, cfg_rwn_o} != stall_snap))
            stall_err++;
        stall_pend = cfg_valid_o && !cfg_ready;
        stall_snap = {cfg_valid_o, cfg_addr_o, cfg_data_o, cfg_rwn_o};
        if (cfg_valid_o && cfg_ready && log_n < 64) begin
            log_beat[log_n] = cfg_rwn_o ? {1'b1, cfg_addr_o, 32'h0} : {1'b0, cfg_addr_o, cfg_data_o};
            log_n++;
            if (cfg_rwn_o && cfg_addr_o == REG_STATUS) begin
                if (log_polls < 16) poll_cyc[log_polls] = cyc;
                log_polls++;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < 64; i++) log_beat[i] = '0;
        log_n = 0;
        log_polls = 0;
        stall_err = 0;
    endtask

    task automatic push_exp(input logic rd, input logic [4:0] a, input logic [31:0] d);
        exp_beat[exp_n] = rd ? {1'b1, a, 32'h0} : {1'b0, a, d};
        exp_n++;
    endtask

    task automatic build_exp(input logic [31:0] opimg, input logic [31:0] arg,
                             input logic [31:0] setup, input int npolls, input bit rd_rsp);
        exp_n = 0;
        push_exp(1'b0, 5'h08, opimg);
        push_exp(1'b0, 5'h09, arg);
        push_exp(1'b0, 5'h0A, setup);
        push_exp(1'b0, 5'h0B, 32'h1);
        for (int i = 0; i < npolls; i++) push_exp(1'b1, 5'h11, 32'h0);
`ifdef UDMA_SDIO_SEQ_RSP_READ_EN
        if (rd_rsp) for (int k = 0; k < 4; k++) push_exp(1'b1, 5'h0C + 5'(k), 32'h0);
`else
        if (rd_rsp) exp_n = exp_n + 0;
`endif
        push_exp(1'b0, 5'h11, 32'h3);
    endtask

    task automatic compare_beats(input string name);
        check({name, "_beat_count"}, 128'(log_n), 128'(exp_n));
        for (int i = 0; i < exp_n; i++)
            check($sformatf("%s_beat%0d", name, i), 128'(log_beat[i]), 128'(exp_beat[i]));
    endtask

    task automatic issue_req(input logic [5:0] op, input logic [31:0] arg,
                             input logic [2:0] rt, input logic [25:0] sd);
        int n;
        n = 0;
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_issue", 128'(req_ready_o), 128'(1));
        req_valid = 1'b1;
        req_op = op;
        req_arg = arg;
        req_rsp_type = rt;
        req_data = sd;
        @(negedge clk);
        req_valid = 1'b0;
        check("req_ready_busy", 128'(req_ready_o), 128'(0));
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_seen", 128'(rsp_valid_o), 128'(1));
    endtask

    task automatic finish_rsp(input string name);
        @(negedge clk);
        check({name, "_rsp_hold"}, 128'(rsp_valid_o), 128'(1));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_rsp_drop"}, 128'(rsp_valid_o), 128'(0));
        check({name, "_idle_again"}, 128'(req_ready_o), 128'(1));
        $display("[TB] %s: beats=%0d polls=%0d status=%04h err=%0d timeout=%0d",
                 name, log_n, log_polls, rsp_status_o, rsp_err_o, rsp_timeout_o);
    endtask

    logic [127:0] exp_rsp_a;
    logic [127:0] exp_rsp_e;
    logic [25:0]  setup_a;

    initial begin
        rstn = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_arg = '0;
        req_rsp_type = '0;
        req_data = '0;
        rsp_ready = 1'b0;
        cfg_ready = 1'b1;
        rsp_mem[0] = 32'h11; rsp_mem[1] = 32'h22; rsp_mem[2] = 32'h33; rsp_mem[3] = 32'h44;
`ifdef UDMA_SDIO_SEQ_RSP_READ_EN
        exp_rsp_a = 128'h00000044_00000033_00000022_00000011;
        exp_rsp_e = 128'h000000D4_000000C3_000000B2_000000A1;
`else
        exp_rsp_a = '0;
        exp_rsp_e = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_req_ready", 128'(req_ready_o), 128'(1));
        check("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
        check("rst_cfg_valid", 128'(cfg_valid_o), 128'(0));
        check("rst_cfg_addr", 128'(cfg_addr_o), 128'(0));
        check("rst_cfg_data", 128'(cfg_data_o), 128'(0));
        check("rst_cfg_rwn", 128'(cfg_rwn_o), 128'(0));
        check("rst_rsp_data", rsp_data_o, 128'(0));
        check("rst_status", 128'(rsp_status_o), 128'(0));
        check("rst_err_timeout", 128'({rsp_err_o, rsp_timeout_o}), 128'(0));
        rstn = 1'b1;
        @(negedge clk);

        // A: op 17, arg 0x200, rsp type 1, eot on the third poll
        setup_a = setup_image(1'b1, 1'b1, 1'b0, 8'd1, 10'd512);
        check("setup_image", 128'(setup_a), 128'h2000103);
        clear_log();
        eot_poll = 3;
        status_done = 32'h1234_0001;
        issue_req(6'd17, 32'h200, 3'd1, setup_a);
        wait_rsp();
        build_exp(32'h1101, 32'h200, 32'h0200_0103, 3, 1'b1);
        compare_beats("A");
        check("A_rsp_data", rsp_data_o, exp_rsp_a);
        check("A_status", 128'(rsp_status_o), 128'h1234);
        check("A_err", 128'(rsp_err_o), 128'(0));
        check("A_timeout", 128'(rsp_timeout_o), 128'(0));
        check("A_gap01", 128'(poll_cyc[1] - poll_cyc[0]), 128'(9));
        check("A_gap12", 128'(poll_cyc[2] - poll_cyc[1]), 128'(9));
        finish_rsp("A");

        // B: same command under random cfg_ready stalls
        clear_log();
        stall_mode = 1;
        issue_req(6'd17, 32'h200, 3'd1, setup_a);
        wait_rsp();
        stall_mode = 0;
        compare_beats("B");
        check("B_stall_stable", 128'(stall_err), 128'(0));
        check("B_rsp_data", rsp_data_o, exp_rsp_a);
        check("B_status", 128'(rsp_status_o), 128'h1234);
        finish_rsp("B");

        // E: error reported on the first poll, op 52, rsp type 5
        clear_log();
        eot_poll = 1;
        status_done = 32'h00A5_0002;
        rsp_mem[0] = 32'hA1; rsp_mem[1] = 32'hB2; rsp_mem[2] = 32'hC3; rsp_mem[3] = 32'hD4;
        issue_req(6'd52, 32'hDEAD_BEEF, 3'd5, 26'h0);
        wait_rsp();
        build_exp(32'h3405, 32'hDEAD_BEEF, 32'h0, 1, 1'b1);
        compare_beats("E");
        check("E_err", 128'(rsp_err_o), 128'(1));
        check("E_status", 128'(rsp_status_o), 128'h00A5);
        check("E_timeout", 128'(rsp_timeout_o), 128'(0));
        check("E_rsp_data", rsp_data_o, exp_rsp_e);
        finish_rsp("E");

        // T: never completes, budget of 7 polls with TIMEOUT_W=3
        clear_log();
        eot_poll = 0;
        issue_req(6'd2, 32'h0, 3'd2, 26'h1);
        wait_rsp();
        build_exp(32'h0202, 32'h0, 32'h1, 7, 1'b0);
        compare_beats("T");
        check("T_timeout", 128'(rsp_timeout_o), 128'(1));
        check("T_err", 128'(rsp_err_o), 128'(0));
        check("T_status", 128'(rsp_status_o), 128'(0));
        check("T_rsp_data", rsp_data_o, 128'(0));
        check("T_gap", 128'(poll_cyc[6] - poll_cyc[5]), 128'(9));
        finish_rsp("T");

        // R: reset while polling, then a clean rerun of command A
        clear_log();
        eot_poll = 0;
        issue_req(6'd17, 32'h200, 3'd1, setup_a);
        begin
            int n;
            n = 0;
            while (!(cfg_valid_o && cfg_addr_o == REG_STATUS) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("R_reached_poll", 128'({cfg_valid_o, cfg_addr_o}), 128'({1'b1, REG_STATUS}));
        rstn = 1'b0;
        #1;
        check("R_cfg_valid", 128'(cfg_valid_o), 128'(0));
        check("R_cfg_bus", 128'({cfg_addr_o, cfg_data_o, cfg_rwn_o}), 128'(0));
        check("R_req_ready", 128'(req_ready_o), 128'(1));
        check("R_rsp_valid", 128'(rsp_valid_o), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("R_idle_after", 128'({req_ready_o, cfg_valid_o}), 128'({1'b1, 1'b0}));
        clear_log();
        eot_poll = 3;
        status_done = 32'h1234_0001;
        rsp_mem[0] = 32'h11; rsp_mem[1] = 32'h22; rsp_mem[2] = 32'h33; rsp_mem[3] = 32'h44;
        issue_req(6'd17, 32'h200, 3'd1, setup_a);
        wait_rsp();
        build_exp(32'h1101, 32'h200, 32'h0200_0103, 3, 1'b1);
        compare_beats("R");
        check("R_rsp_data", rsp_data_o, exp_rsp_a);
        check("R_status", 128'(rsp_status_o), 128'h1234);
        finish_rsp("R");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
